// File: rtl/ad7606_frame_packer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ad7606_frame_packer                                                         |
// | Gathers one sample per AD7606 channel into a tagged frame, buffers whole    |
// | frames in a FIFO and streams them out as 16-bit valid/ready words.          |
// | Optional: AD7606_PACK_CSUM_EN appends a 16-bit wrapping checksum word.      |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module ad7606_frame_packer #(
  parameter int         P_FIFO_DEPTH = 32,
  parameter logic [7:0] P_HEADER_TAG = 8'hA5
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [15:0] i_user_data_1,
  input  logic [15:0] i_user_data_2,
  input  logic [15:0] i_user_data_3,
  input  logic [15:0] i_user_data_4,
  input  logic [15:0] i_user_data_5,
  input  logic [15:0] i_user_data_6,
  input  logic [15:0] i_user_data_7,
  input  logic [15:0] i_user_data_8,
  input  logic        i_user_data_valid_1,
  input  logic        i_user_data_valid_2,
  input  logic        i_user_data_valid_3,
  input  logic        i_user_data_valid_4,
  input  logic        i_user_data_valid_5,
  input  logic        i_user_data_valid_6,
  input  logic        i_user_data_valid_7,
  input  logic        i_user_data_valid_8,
  output logic [15:0] o_tx_data,
  output logic        o_tx_valid,
  input  logic        i_tx_ready,
  output logic        o_tx_last,
  output logic [15:0] o_frame_cnt,
  output logic [7:0]  o_drop_cnt,
  output logic        o_seq_err,
  output logic        o_overflow
);

  localparam int C_AW = $clog2(P_FIFO_DEPTH);
`ifdef AD7606_PACK_CSUM_EN
  localparam int C_FRAME_LEN = 10;
`else
  localparam int C_FRAME_LEN = 9;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HDR  = 2'd1,
    S_DATA = 2'd2
`ifdef AD7606_PACK_CSUM_EN
    , S_CSUM = 2'd3
`endif
  } state_t;

  state_t       r_state, w_state_nxt;
  logic [15:0]  w_in_data [8];
  logic [7:0]   w_in_valid;
  logic [15:0]  r_hold [8];
  logic [15:0]  w_hold_nxt [8];
  logic [15:0]  r_shadow [8];
  logic [7:0]   r_mask, w_mask_nxt;
  logic         w_repeat, w_complete, w_admit, w_space_ok;
  logic [7:0]   r_seq;
  logic [2:0]   r_idx;
  logic [15:0]  r_frame_cnt;
  logic [7:0]   r_drop_cnt;
  logic         r_seq_err, r_overflow;
  logic         w_wr_en, w_pop;
  logic [16:0]  w_wr_data, w_head;
  logic [16:0]  r_mem [P_FIFO_DEPTH];
  logic [C_AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [C_AW:0]   r_count;

  always_comb begin
    w_in_data[0] = i_user_data_1;  w_in_data[1] = i_user_data_2;
    w_in_data[2] = i_user_data_3;  w_in_data[3] = i_user_data_4;
    w_in_data[4] = i_user_data_5;  w_in_data[5] = i_user_data_6;
    w_in_data[6] = i_user_data_7;  w_in_data[7] = i_user_data_8;
    w_in_valid = {i_user_data_valid_8, i_user_data_valid_7, i_user_data_valid_6,
                  i_user_data_valid_5, i_user_data_valid_4, i_user_data_valid_3,
                  i_user_data_valid_2, i_user_data_valid_1};
  end

  // A repeated channel restarts the partial frame with only the new samples.
  always_comb begin
    w_repeat   = |(w_in_valid & r_mask);
    w_mask_nxt = w_repeat ? w_in_valid : (r_mask | w_in_valid);
    w_complete = (w_mask_nxt == 8'hFF);
    for (int i = 0; i < 8; i++) begin
      w_hold_nxt[i] = w_in_valid[i] ? w_in_data[i] : r_hold[i];
    end
    w_space_ok = (r_count <= (C_AW+1)'(P_FIFO_DEPTH - C_FRAME_LEN));
    w_admit    = w_complete && (r_state == S_IDLE) && w_space_ok;
  end

`ifdef AD7606_PACK_CSUM_EN
  logic [15:0] w_csum;
  always_comb begin
    w_csum = '0;
    for (int i = 0; i < 8; i++) begin
      w_csum = w_csum + r_shadow[i];
    end
  end
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_wr_en     = 1'b0;
    w_wr_data   = '0;
    case (r_state)
      S_IDLE: if (w_admit) w_state_nxt = S_HDR;
      S_HDR: begin
        w_wr_en     = 1'b1;
        w_wr_data   = {1'b0, P_HEADER_TAG, r_seq};
        w_state_nxt = S_DATA;
      end
      S_DATA: begin
        w_wr_en   = 1'b1;
        w_wr_data = {1'b0, r_shadow[r_idx]};
        if (r_idx == 3'd7) begin
`ifdef AD7606_PACK_CSUM_EN
          w_state_nxt = S_CSUM;
`else
          w_wr_data[16] = 1'b1;
          w_state_nxt   = S_IDLE;
`endif
        end
      end
`ifdef AD7606_PACK_CSUM_EN
      S_CSUM: begin
        w_wr_en     = 1'b1;
        w_wr_data   = {1'b1, w_csum};
        w_state_nxt = S_IDLE;
      end
`endif
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_mask      <= '0;
      r_seq       <= '0;
      r_idx       <= '0;
      r_frame_cnt <= '0;
      r_drop_cnt  <= '0;
      r_seq_err   <= 1'b0;
      r_overflow  <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        r_hold[i]   <= '0;
        r_shadow[i] <= '0;
      end
    end else begin
      r_mask <= w_complete ? 8'h00 : w_mask_nxt;
      for (int i = 0; i < 8; i++) r_hold[i] <= w_hold_nxt[i];
      if (w_repeat) r_seq_err <= 1'b1;
      if (w_complete) begin
        if (w_admit) begin
          for (int i = 0; i < 8; i++) r_shadow[i] <= w_hold_nxt[i];
          r_frame_cnt <= r_frame_cnt + 16'd1;
        end else begin
          r_overflow <= 1'b1;
          if (r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 8'd1;
        end
      end
      if (r_state == S_HDR) begin
        r_seq <= r_seq + 8'd1;
        r_idx <= '0;
      end else if (r_state == S_DATA) begin
        r_idx <= r_idx + 3'd1;
      end
    end
  end

  // Admission guarantees space, so writes never check for full.
  assign w_pop = (r_count != '0) && i_tx_ready;

  always_ff @(posedge i_clk) begin
    if (w_wr_en) r_mem[r_wr_ptr] <= w_wr_data;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)   r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + (C_AW+1)'(w_wr_en) - (C_AW+1)'(w_pop);
    end
  end

  assign w_head      = r_mem[r_rd_ptr];
  assign o_tx_valid  = (r_count != '0);
  assign o_tx_data   = o_tx_valid ? w_head[15:0] : 16'h0000;
  assign o_tx_last   = o_tx_valid ? w_head[16] : 1'b0;
  assign o_frame_cnt = r_frame_cnt;
  assign o_drop_cnt  = r_drop_cnt;
  assign o_seq_err   = r_seq_err;
  assign o_overflow  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_ad7606_frame_packer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_ad7606_frame_packer                                                      |
// | Directed stimulus with a cycle-level frame/stream model and literal checks. |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_ad7606_frame_packer;

`ifdef AD7606_PACK_CSUM_EN
  localparam int C_L = 10;
`else
  localparam int C_L = 9;
`endif
  localparam int C_DEPTH = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] d [8];
  logic [7:0]  v = '0;
  logic        ready = 1'b0;
  logic [15:0] tx_data, frame_cnt;
  logic        tx_valid, tx_last, seq_err, overflow;
  logic [7:0]  drop_cnt;

  always #5 clk = ~clk;

  ad7606_frame_packer #(.P_FIFO_DEPTH(C_DEPTH), .P_HEADER_TAG(8'hA5)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_user_data_1(d[0]), .i_user_data_2(d[1]), .i_user_data_3(d[2]), .i_user_data_4(d[3]),
    .i_user_data_5(d[4]), .i_user_data_6(d[5]), .i_user_data_7(d[6]), .i_user_data_8(d[7]),
    .i_user_data_valid_1(v[0]), .i_user_data_valid_2(v[1]), .i_user_data_valid_3(v[2]),
    .i_user_data_valid_4(v[3]), .i_user_data_valid_5(v[4]), .i_user_data_valid_6(v[5]),
    .i_user_data_valid_7(v[6]), .i_user_data_valid_8(v[7]),
    .o_tx_data(tx_data), .o_tx_valid(tx_valid), .i_tx_ready(ready), .o_tx_last(tx_last),
    .o_frame_cnt(frame_cnt), .o_drop_cnt(drop_cnt), .o_seq_err(seq_err), .o_overflow(overflow)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 30) $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model state: words become visible at a given model cycle.
  typedef struct { int vis; logic [16:0] w; } ent_t;
  ent_t        mq[$];
  logic [16:0] got[$];
  bit          seen [8];
  logic [15:0] hold [8];
  logic [7:0]  m_seq = 0;
  logic [15:0] m_frames = 0;
  int          m_drops = 0;
  bit          m_seq_err = 0, m_ovf = 0;
  int          busy_until = -1000;
  int          cyc = 0;
  bit          mon_en = 0;

  always @(negedge clk) begin
    if (mon_en) begin
      bit          exp_v, rep, all;
      logic [16:0] exp_w;
      int          occ;
      logic [15:0] sum;
      exp_v = (mq.size() > 0) && (mq[0].vis <= cyc);
      exp_w = exp_v ? mq[0].w : 17'h0;
      chk("tx_valid", 32'(tx_valid), 32'(exp_v));
      chk("tx_word", 32'({tx_last, tx_data}), 32'(exp_w));
      chk("frame_cnt", 32'(frame_cnt), 32'(m_frames));
      chk("drop_cnt", 32'(drop_cnt), 32'(m_drops));
      chk("seq_err", 32'(seq_err), 32'(m_seq_err));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      if (rst) begin
        mq.delete();
        for (int i = 0; i < 8; i++) begin seen[i] = 0; hold[i] = 0; end
        m_seq = 0; m_frames = 0; m_drops = 0; m_seq_err = 0; m_ovf = 0;
        busy_until = -1000;
      end else begin
        occ = 0;
        foreach (mq[i]) if (mq[i].vis <= cyc) occ++;
        rep = 0;
        for (int i = 0; i < 8; i++) if (v[i] && seen[i]) rep = 1;
        if (rep) begin
          m_seq_err = 1;
          for (int i = 0; i < 8; i++) seen[i] = 0;
        end
        for (int i = 0; i < 8; i++) if (v[i]) begin seen[i] = 1; hold[i] = d[i]; end
        all = 1;
        for (int i = 0; i < 8; i++) if (!seen[i]) all = 0;
        if (all) begin
          for (int i = 0; i < 8; i++) seen[i] = 0;
          if (cyc > busy_until && (C_DEPTH - occ) >= C_L) begin
            busy_until = cyc + C_L;
            mq.push_back('{cyc + 2, {1'b0, 8'hA5, m_seq}});
            sum = 0;
            for (int i = 0; i < 8; i++) begin
              sum = sum + hold[i];
              mq.push_back('{cyc + 3 + i, {(i == 7 && C_L == 9), hold[i]}});
            end
            if (C_L == 10) mq.push_back('{cyc + 11, {1'b1, sum}});
            m_seq++;
            m_frames++;
          end else begin
            m_ovf = 1;
            if (m_drops < 255) m_drops++;
          end
        end
        if (exp_v && ready) begin
          got.push_back({tx_last, tx_data});
          void'(mq.pop_front());
        end
      end
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic pulse_ch(input int ch, input logic [15:0] val);
    d[ch] = val; v = 8'(1 << ch);
    tick();
    v = '0;
  endtask

  task automatic frame_all(input logic [15:0] base, input logic [15:0] step);
    for (int i = 0; i < 8; i++) d[i] = base + step * 16'(i);
    v = 8'hFF;
    tick();
    v = '0;
  endtask

  task automatic wait_got(input int n, input string name);
    int k;
    k = 0;
    while (got.size() < n && k < 300) begin tick(); k++; end
    chk(name, 32'(got.size()), 32'(n));
  endtask

  logic [16:0] csum_last;

  initial begin
    for (int i = 0; i < 8; i++) d[i] = '0;
    tick(); tick();
    mon_en = 1;
    tick();
    rst = 0;
    chk("reset_valid", 32'(tx_valid), 32'd0);
    chk("reset_frame_cnt", 32'(frame_cnt), 32'd0);

    // Sequential channels 1..8, two cycles apart.
    ready = 1;
    for (int i = 0; i < 8; i++) begin pulse_ch(i, 16'(i + 1)); tick(); end
    wait_got(C_L, "t1_len");
    chk("t1_hdr", 32'(got[0]), 32'h0A500);
    chk("t1_w1", 32'(got[1]), 32'h00001);
    chk("t1_w8", 32'(got[8]), (C_L == 9) ? 32'h10008 : 32'h00008);
    if (C_L == 10) chk("t1_csum", 32'(got[9]), 32'h10024);
    chk("t1_frame_cnt", 32'(frame_cnt), 32'd1);

    // Repeat of channel 1 restarts the frame.
    got.delete();
    pulse_ch(0, 16'h0101); tick();
    pulse_ch(1, 16'h0102); tick();
    pulse_ch(2, 16'h0103); tick();
    pulse_ch(0, 16'h0111); tick();
    for (int i = 1; i < 8; i++) begin pulse_ch(i, 16'h0100 + 16'(i + 1)); tick(); end
    wait_got(C_L, "t2_len");
    chk("t2_hdr", 32'(got[0]), 32'h0A501);
    chk("t2_ch1", 32'(got[1]), 32'h00111);
    chk("t2_seq_err", 32'(seq_err), 32'd1);
    chk("t2_drop", 32'(drop_cnt), 32'd0);

    // Back-pressure until a frame must be dropped.
    got.delete();
    ready = 0;
    for (int f = 0; f < 4; f++) begin
      frame_all(16'h1000 * 16'(f + 1), 16'd1);
      repeat (15) tick();
    end
    chk("t3_drop", 32'(drop_cnt), 32'd1);
    chk("t3_ovf", 32'(overflow), 32'd1);
    chk("t3_frame_cnt", 32'(frame_cnt), 32'd5);
    ready = 1;
    wait_got(3 * C_L, "t3_len");
    repeat (10) tick();
    chk("t3_len_final", 32'(got.size()), 32'(3 * C_L));
    chk("t3_hdr0", 32'(got[0]), 32'h0A502);
    chk("t3_hdr1", 32'(got[C_L]), 32'h0A503);
    chk("t3_hdr2", 32'(got[2 * C_L]), 32'h0A504);
    chk("t3_d2", 32'(got[2 * C_L + 1]), 32'h03000);

    // All eight channels in one cycle.
    got.delete();
    frame_all(16'hFFFF, 16'd0);
    wait_got(C_L, "t4_len");
    chk("t4_hdr", 32'(got[0]), 32'h0A505);
    csum_last = (C_L == 10) ? 17'h1FFF8 : 17'h1FFFF;
    chk("t4_last", 32'(got[C_L - 1]), 32'(csum_last));

    // Reset in the middle of a DATA write with five words buffered.
    got.delete();
    ready = 0;
    frame_all(16'h0500, 16'd1);
    repeat (5) tick();
    rst = 1;
    tick();
    rst = 0;
    chk("t5_valid", 32'(tx_valid), 32'd0);
    chk("t5_frame_cnt", 32'(frame_cnt), 32'd0);
    chk("t5_drop", 32'(drop_cnt), 32'd0);
    chk("t5_seq_err", 32'(seq_err), 32'd0);
    chk("t5_ovf", 32'(overflow), 32'd0);
    ready = 1;
    repeat (20) tick();
    chk("t5_no_remnant", 32'(got.size()), 32'd0);
    frame_all(16'h0200, 16'd1);
    wait_got(C_L, "t5_len");
    chk("t5_hdr", 32'(got[0]), 32'h0A500);
    chk("t5_d1", 32'(got[1]), 32'h00200);

    // Ready toggling every cycle over three frames.
    got.delete();
    fork
      begin
        for (int i = 0; i < 100; i++) begin ready = i[0]; tick(); end
      end
      begin
        for (int f = 0; f < 3; f++) begin
          frame_all(16'h0300 + 16'h0010 * 16'(f), 16'd1);
          repeat (15) tick();
        end
      end
    join
    ready = 1;
    wait_got(3 * C_L, "t6_len");
    for (int f = 0; f < 3; f++) begin
      chk("t6_hdr", 32'(got[f * C_L]), 32'h0A501 + 32'(f));
      chk("t6_d1", 32'(got[f * C_L + 1]), 32'h00300 + 32'h10 * 32'(f));
    end
    repeat (5) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ad7606_frame_packer.md
# ad7606_frame_packer

Sits directly downstream of the AD7606 parallel driver and consumes its eight per-channel sample/valid pairs. Assembles one sample from each of the eight channels into a frame, tags it with a header word, and buffers it in an internal FIFO. Frames leave as a 16-bit valid/ready word stream toward the host link, so the ADC path is never stalled by back-pressure.

## Interface
- P_FIFO_DEPTH, 32: FIFO depth in 16-bit words; power of two, ≥16.
- P_HEADER_TAG, 8'hA5: upper byte of every header word.

- i_clk  input  1  system clock
- i_rst  input  1  reset; synchronous, active-high
- i_user_data_N (N=1..8)  input  16  channel N sample from driver
- i_user_data_valid_N (N=1..8)  input  1  channel N sample strobe, 1-cycle pulse
- o_tx_data  output  16  stream word
- o_tx_valid  output  1  stream word available
- i_tx_ready  input  1  consumer accepts word
- o_tx_last  output  1  marks final word of a frame
- o_frame_cnt  output  16  frames accepted into FIFO, wraps
- o_drop_cnt  output  8  frames dropped, saturates at 255
- o_seq_err  output  1  sticky: channel repeated before frame complete
- o_overflow  output  1  sticky: frame dropped for lack of space or busy writer

## Operation
- Capture: eight 16-bit holding registers plus an 8-bit seen-mask. A valid on channel N loads holding reg N and sets mask[N]. Several valids in one cycle are all accepted.
- Repeat channel: a valid on a channel whose mask bit is already set means the partial frame is discarded. The mask is cleared and then only the new sample's bit is set. o_seq_err is set; o_drop_cnt is not incremented.
- Frame complete when the mask becomes all-ones, including the cycle the last bit sets. On completion, all eight holding values (including same-cycle data) are copied to shadow registers and the mask is cleared.
- Writer FSM states:
  - IDLE: waiting for a completed frame.
  - HDR: writes {P_HEADER_TAG, seq[7:0]}.
  - DATA: writes shadow 1..8, one word per cycle.
  - CSUM: present only with the macro (see Configuration).
  - The last state returns to IDLE.
- Frame length L = 9 words, or 10 with the macro.
- Admission is checked on the completion cycle. A frame is accepted only if the writer is in IDLE and FIFO free space ≥ L.
  - Accepted: writer enters HDR, seq increments after the header is written, and o_frame_cnt increments by 1 (mod 2^16).
  - Rejected: shadow is not loaded, o_overflow is set, and o_drop_cnt increments (saturating).
- Frames are never partially written to the FIFO.
- FIFO stores 17 bits: {last, data}. Show-ahead output: o_tx_valid = not empty, and o_tx_data/o_tx_last are the head entry. A word pops when o_tx_valid && i_tx_ready.
- Simultaneous FIFO write and pop on a full FIFO cannot occur, because admission guarantees space.
- Sticky flags clear only on reset.

## Timing
- Reset values: o_tx_data = 0, o_tx_valid = 0, o_tx_last = 0, o_frame_cnt = 0, o_drop_cnt = 0, o_seq_err = 0, o_overflow = 0. The FIFO, mask and seq are also cleared.
- Reset mid-frame or mid-write flushes everything. No remnant words appear after reset deasserts.
- The completing valid at cycle T leads to:
  - shadow loaded and FSM in HDR at T+1;
  - header in FIFO at T+2, with o_tx_valid high at T+2 if the FIFO was empty;
  - the last word written at T+L+1.
- With i_tx_ready held high, the stream outputs one word per cycle with no bubbles inside a frame.
- o_tx_data/o_tx_valid hold stable while o_tx_valid && !i_tx_ready.
- The writer is busy for L cycles. A frame completing during that window is rejected. The driver's minimum frame spacing (≥16 cycles) never triggers this in normal operation.

## Configuration
- AD7606_PACK_CSUM_EN defined:
  - L = 10; the CSUM state writes the 16-bit wrapping sum of the eight data words with last = 1.
  - The admission threshold is 10 words.
- AD7606_PACK_CSUM_EN undefined:
  - L = 9; the CSUM state and adder are absent, and channel 8's word carries last = 1.

## Test plan
- Eight valids for channels 1..8 with values 16'h0001..16'h0008, spaced 2 cycles, i_tx_ready = 1 → stream A500, 0001..0008 (last on 0008; with macro, extra 0024 with last). o_frame_cnt = 1.
- Channels 1,2,3 then 1 again, followed by 2..8 → one frame emitted, containing the second channel-1 sample. o_seq_err = 1, o_drop_cnt = 0.
- i_tx_ready = 0, frames pushed until free space < L → the next frame is dropped, o_overflow = 1, o_drop_cnt = 1. Raising ready drains only whole frames, and header seq values are consecutive.
- All eight valids in one cycle with data 16'hFFFF → frame accepted; with the macro, checksum = 16'hFFF8.
- Assert i_rst during a DATA write with 5 words buffered → all outputs and counters are 0 next cycle, and o_tx_valid stays low until a new full frame arrives.
- Alternate i_tx_ready every cycle over 3 frames → no word lost or duplicated, and data is held while stalled.
